// File: rtl/at_response_receiver.sv
// 8N1 UART receive stage: packs byte pairs into 16-bit FIFO words and ends a response on CR LF.
// Optional idle-timeout completion is built only when AT_RX_TIMEOUT_EN is defined.
module at_response_receiver #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        line_in,
  input  logic        fifo_full,
  output logic [15:0] data,
  output logic        wr_en,
  output logic        done,
  output logic        overflow,
  output logic        framing_error,
  output logic        timeout
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_START, ST_START_BIT, ST_DATA_BITS,
    ST_STOP_BIT, ST_ACCEPT, ST_EMIT, ST_DONE
  } state_t;

  state_t        state_reg;
  logic          sync1_reg, line_reg;
  logic [CW-1:0] clk_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg, prev_reg;
  logic [15:0]   word_reg, data_reg;
  logic          half_reg, term_reg, done_reg, overflow_reg, framing_reg;
  logic          is_term;

`ifdef AT_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  logic [TW-1:0] to_cnt_reg;
  logic          timeout_reg;
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      line_reg  <= 1'b1;
    end else begin
      sync1_reg <= line_in;
      line_reg  <= sync1_reg;
    end
  end

  assign is_term       = (prev_reg == 8'h0D) && (shift_reg == 8'h0A);
  // An abort during EMIT must not leak a strobe, hence the start term.
  assign wr_en         = (state_reg == ST_EMIT) && start && !fifo_full;
  assign data          = wr_en ? word_reg : data_reg;
  assign done          = done_reg;
  assign overflow      = overflow_reg;
  assign framing_error = framing_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      prev_reg     <= '0;
      word_reg     <= '0;
      data_reg     <= '0;
      half_reg     <= 1'b0;
      term_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      framing_reg  <= 1'b0;
`ifdef AT_RX_TIMEOUT_EN
      to_cnt_reg   <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else if (!start && state_reg != ST_IDLE && state_reg != ST_DONE) begin
      state_reg <= ST_IDLE;
      half_reg  <= 1'b0;
      term_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            half_reg     <= 1'b0;
            term_reg     <= 1'b0;
            prev_reg     <= '0;
            overflow_reg <= 1'b0;
            framing_reg  <= 1'b0;
`ifdef AT_RX_TIMEOUT_EN
            to_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
`endif
            state_reg    <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (!line_reg) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= ST_START_BIT;
          end
`ifdef AT_RX_TIMEOUT_EN
          else if (to_cnt_reg == TO_LAST) begin
            timeout_reg <= 1'b1;
            if (half_reg) begin
              word_reg[7:0] <= 8'h00;
              term_reg      <= 1'b1;
              state_reg     <= ST_EMIT;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
`endif
        end
        ST_START_BIT: begin
          if (clk_cnt_reg == HALF_LAST) begin
            clk_cnt_reg <= '0;
            state_reg   <= line_reg ? ST_WAIT_START : ST_DATA_BITS;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        ST_DATA_BITS: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {line_reg, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) state_reg <= ST_STOP_BIT;
            else bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        ST_STOP_BIT: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            if (line_reg) begin
              state_reg <= ST_ACCEPT;
            end else begin
              framing_reg <= 1'b1;
              state_reg   <= ST_WAIT_START;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CW'(1);
          end
        end
        ST_ACCEPT: begin
          prev_reg <= shift_reg;
`ifdef AT_RX_TIMEOUT_EN
          to_cnt_reg <= '0;
`endif
          if (!half_reg) begin
            word_reg[15:8] <= shift_reg;
            half_reg       <= 1'b1;
            if (is_term) begin
              word_reg[7:0] <= 8'h00;
              term_reg      <= 1'b1;
              state_reg     <= ST_EMIT;
            end else begin
              state_reg <= ST_WAIT_START;
            end
          end else begin
            word_reg[7:0] <= shift_reg;
            term_reg      <= is_term;
            state_reg     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          half_reg <= 1'b0;
          if (fifo_full) overflow_reg <= 1'b1;
          else data_reg <= word_reg;
          if (term_reg) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_WAIT_START;
          end
        end
        ST_DONE: begin
          if (!start) begin
            done_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_at_response_receiver.sv
// Directed and randomized bench for at_response_receiver; expected words come from a byte-level model.
module tb_at_response_receiver;
  localparam int CPB     = 16;
  localparam int TO_CLKS = 3000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        line_in = 1'b1;
  logic        fifo_full = 1'b0;
  logic [15:0] data;
  logic        wr_en, done, overflow, framing_error, timeout;

  int vectors = 0;
  int miscompares = 0;

  at_response_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO_CLKS)) dut (
    .clock(clock), .resetn(resetn), .start(start), .line_in(line_in),
    .fifo_full(fifo_full), .data(data), .wr_en(wr_en), .done(done),
    .overflow(overflow), .framing_error(framing_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  logic [15:0] got_q[$];
  int          cyc = 0;
  int          last_wr_cyc = -1;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      got_q.push_back(data);
      last_wr_cyc = cyc;
      $display("strobe cycle %0d data %04h", cyc, data);
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte stream plus stop-bit validity in, expected FIFO words out.
  logic [7:0]  msg_b[$];
  bit          msg_ok[$];
  logic [15:0] exp_q[$];
  bit          exp_fe;

  task automatic add(input logic [7:0] b, input bit ok);
    msg_b.push_back(b);
    msg_ok.push_back(ok);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b1);
  endtask

  task automatic build_expected();
    bit         have_hi = 1'b0;
    logic [7:0] hi = 8'h00;
    logic [7:0] prev = 8'h00;
    logic [7:0] b;
    exp_q.delete();
    exp_fe = 1'b0;
    for (int i = 0; i < msg_b.size(); i++) begin
      if (!msg_ok[i]) begin
        exp_fe = 1'b1;
        continue;
      end
      b = msg_b[i];
      if (prev == 8'h0D && b == 8'h0A) begin
        exp_q.push_back(have_hi ? {hi, b} : {b, 8'h00});
        break;
      end
      if (have_hi) begin
        exp_q.push_back({hi, b});
        have_hi = 1'b0;
      end else begin
        hi = b;
        have_hi = 1'b1;
      end
      prev = b;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    line_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      line_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    line_in = ok;
    repeat (CPB) @(negedge clock);
    line_in = 1'b1;
    if (!ok) repeat (CPB) @(negedge clock);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(negedge clock);
    check({tag, "_done_drop"}, done, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic run_msg(input string tag, input bit rand_gaps);
    build_expected();
    got_q.delete();
    done_rise_cyc = -1;
    start = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < msg_b.size(); i++) begin
      send_byte(msg_b[i], msg_ok[i]);
      if (rand_gaps) repeat ($urandom_range(0, 20)) @(negedge clock);
    end
    wait_done(tag, 40);
    compare_words(tag);
    check({tag, "_done_timing"}, done_rise_cyc, last_wr_cyc + 1);
    check({tag, "_framing"}, framing_error, exp_fe);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    $display("message %s: %0d bytes, %0d words", tag, msg_b.size(), got_q.size());
    msg_b.delete();
    msg_ok.delete();
    release_start(tag);
  endtask

  int n_body;
  int kind;

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    check("rst_data", data, 16'h0000);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_framing", framing_error, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    add_str("OK\r\n");
    run_msg("ok", 1'b0);
    check("ok_last_data", data, 16'h0D0A);

    add_str("ERROR\r\n");
    run_msg("error", 1'b0);

    add(8'h41, 1'b0);
    add_str("OK\r\n");
    run_msg("framing", 1'b0);

    // Full FIFO during the first EMIT: that word is lost
    got_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clock);
    send_byte("O", 1'b1);
    fifo_full = 1'b1;
    send_byte("K", 1'b1);
    fifo_full = 1'b0;
    check("ovf_flag_set", overflow, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_done("ovf", 40);
    check("ovf_nwords", got_q.size(), 1);
    if (got_q.size() > 0) check("ovf_word0", got_q[0], 16'h0D0A);
    check("ovf_flag", overflow, 1'b1);
    release_start("ovf");

    // Abort midway through 'K'
    got_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clock);
    send_byte("O", 1'b1);
    line_in = 1'b0;
    repeat (CPB * 4) @(negedge clock);
    start = 1'b0;
    repeat (CPB * 6) @(negedge clock);
    line_in = 1'b1;
    repeat (CPB) @(negedge clock);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    repeat (20) @(negedge clock);
    check("abort_nwords", got_q.size(), 0);
    check("abort_done", done, 1'b0);
    add_str("OK\r\n");
    run_msg("after_abort", 1'b0);

    // Reset pulse mid-byte clears everything asynchronously
    got_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clock);
    send_byte(8'h41, 1'b0);
    send_byte("O", 1'b1);
    send_byte("K", 1'b1);
    check("rstmid_pre_data", data, 16'h4F4B);
    check("rstmid_pre_framing", framing_error, 1'b1);
    line_in = 1'b0;
    repeat (CPB * 3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rstmid_data", data, 16'h0000);
    check("rstmid_wr_en", wr_en, 1'b0);
    check("rstmid_done", done, 1'b0);
    check("rstmid_overflow", overflow, 1'b0);
    check("rstmid_framing", framing_error, 1'b0);
    check("rstmid_timeout", timeout, 1'b0);
    @(negedge clock);
    start = 1'b0;
    line_in = 1'b1;
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // Randomized messages
    for (int m = 0; m < 6; m++) begin
      n_body = $urandom_range(0, 8);
      for (int k = 0; k < n_body; k++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          add(8'h0D, 1'b1);
          add(8'($urandom_range(32, 126)), 1'b1);
        end else if (kind == 1) begin
          add(8'h0A, 1'b1);
        end else if (kind == 2) begin
          add(8'($urandom_range(0, 255)), 1'b0);
        end else begin
          add(8'($urandom_range(32, 126)), 1'b1);
        end
      end
      add(8'h0D, 1'b1);
      add(8'h0A, 1'b1);
      run_msg($sformatf("rand%0d", m), 1'b1);
    end

    // "A" then silence
    got_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clock);
    send_byte("A", 1'b1);
    for (int n = 0; n < TO_CLKS + 200 && done !== 1'b1; n++) @(negedge clock);
`ifdef AT_RX_TIMEOUT_EN
    check("to_done", done, 1'b1);
    check("to_nwords", got_q.size(), 1);
    if (got_q.size() > 0) check("to_word0", got_q[0], 16'h4100);
    check("to_flag", timeout, 1'b1);
`else
    check("to_done", done, 1'b0);
    check("to_nwords", got_q.size(), 0);
    check("to_flag", timeout, 1'b0);
`endif
    start = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/at_response_receiver.md
# at_response_receiver

- Serial receive stage feeding the AT-response FIFO.
- Samples the HC-05 TXD line (`fpga_rxd`) and deserialises 8N1 UART bytes.
- Packs byte pairs into 16-bit words and writes them to the FIFO through a single-cycle write strobe.
- Ends a response on the CR LF terminator and raises `done` for the top-level FSM.

## Interface
- `CLKS_PER_BIT`, 1302, clock cycles per UART bit (50 MHz / 38400 baud); minimum 8.
- `TIMEOUT_CLKS`, 50_000_000, idle cycles before forced completion (used only with the macro).
- `clock` in 1: system clock. One clock domain only.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: level. High arms reception; low aborts it or acknowledges `done`.
- `line_in` in 1: raw asynchronous UART line; idles high.
- `fifo_full` in 1: downstream FIFO full flag.
- `data` out 16: packed word, valid when `wr_en`=1. First byte in [15:8], second in [7:0].
- `wr_en` out 1: one-cycle FIFO write strobe.
- `done` out 1: response complete. Held until `start` falls.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `framing_error` out 1: sticky; a byte had a stop bit of 0.
- `timeout` out 1: sticky; completion was forced by the idle timeout.

## Operation
- **Input sync:** `line_in` passes through a 2-flop synchroniser that resets to 1. All logic uses the synchronised value.
- **States:** IDLE, WAIT_START, START_BIT, DATA_BITS, STOP_BIT, ACCEPT, EMIT, DONE.
- **IDLE:** when `start`=1, clear the half-word flag, the previous-byte register and all sticky flags, then go to WAIT_START.
- **WAIT_START:** when the line is 0, clear the bit counter and go to START_BIT.
- **START_BIT:** after `CLKS_PER_BIT/2` cycles, sample the line.
  - 0: go to DATA_BITS.
  - 1: treat as a glitch and return to WAIT_START.
- **DATA_BITS:** sample every `CLKS_PER_BIT` cycles, LSB first, for 8 bits, then go to STOP_BIT.
- **STOP_BIT:** sample after `CLKS_PER_BIT` cycles.
  - 0: set `framing_error`, discard the byte, return to WAIT_START.
  - 1: go to ACCEPT.
- **ACCEPT:**
  - Half-word empty: byte goes to [15:8] and the half flag is set.
  - Half-word full: byte goes to [7:0] and the state goes to EMIT.
  - Terminator (previous byte 0x0D, this byte 0x0A): force EMIT. If the byte landed in [15:8], pad [7:0] with 0x00. Mark the response terminated.
  - Otherwise, with no word to emit, return to WAIT_START.
  - The previous-byte register updates on every accepted byte.
- **EMIT:**
  - `fifo_full`=0: `wr_en`=1 for exactly this cycle and `data` is driven.
  - `fifo_full`=1: `wr_en` stays 0, `overflow` is set, and the word is lost.
  - Clear the half flag. Go to DONE if terminated, otherwise WAIT_START.
- **DONE:** `done`=1. When `start`=0, go to IDLE. `done` deasserts on that transition.
- **Abort:** `start`=0 in any state other than IDLE or DONE returns to IDLE. Any partial word is discarded, no strobe is issued, and `done` stays 0.
- **Non-terminators:** a CR followed by anything other than LF is ordinary data. A lone LF is ordinary data.

## Timing
- **Reset values:** `data`=0x0000; `wr_en`, `done`, `overflow`, `framing_error`, `timeout` all 0; synchroniser flops 1; state IDLE.
- **Reset mid-byte:** returns to these values immediately (asynchronous).
- **Start edge to start bit:** the falling edge on `line_in` reaches the FSM after 2 cycles.
- **Stop-bit sample:** taken 9.5×`CLKS_PER_BIT` (rounded down) cycles after START_BIT entry.
- **ACCEPT:** the cycle after the stop-bit sample.
- **Strobe:** `wr_en` in the cycle after ACCEPT.
- **Completion:** `done` rises the cycle after the terminating EMIT.
- **`data`:** holds its last value between strobes.
- **Sticky flags:** remain set until the next IDLE→WAIT_START arming, or reset.
- **Back-to-back bytes:** accepted with no idle gap. A new start bit is searched for immediately after ACCEPT/EMIT, which takes at most 2 cycles, well inside the stop-bit's second half.

## Configuration
- **`AT_RX_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_START. It is cleared on arming and on every accepted byte.
  - On reaching `TIMEOUT_CLKS`: any pending half-word is emitted padded with 0x00 (same EMIT rules), `timeout` is set, and the state goes to DONE.
- **Not defined:** no counter is built, `timeout` is tied to 0, and the block waits indefinitely for CR LF.

## Test plan
- **"OK\r\n"** at `CLKS_PER_BIT`=16 → `wr_en` pulses with 0x4F4B, then 0x0D0A; `done`=1 the cycle after the second strobe; all flags 0.
- **"ERROR\r\n"** → strobes with 0x4552, 0x524F, 0x520D, 0x0A00; `done`=1.
- **Byte 0x41 with stop bit 0, then "OK\r\n"** → `framing_error`=1, 0x41 discarded; words 0x4F4B and 0x0D0A still written; `done`=1.
- **`fifo_full`=1 during the first EMIT of "OK\r\n"** → no strobe for 0x4F4B and `overflow`=1; 0x0D0A written after `fifo_full` drops.
- **Interruptions:**
  - `start` dropped midway through the "K" byte → back to IDLE with no further strobes and `done`=0.
  - `resetn` pulsed mid-byte instead → all outputs 0 immediately.
- **"A" then silence for `TIMEOUT_CLKS`:**
  - With `AT_RX_TIMEOUT_EN`: 0x4100 written, `timeout`=1, `done`=1.
  - Without it: no strobe and `done` stays 0.
